// File: rtl/lif_spike_rate_decoder_if.sv
// lif_spike_rate_decoder_if: valid/ready event stream carrying (index, count, last) per neuron.
interface lif_spike_rate_decoder_if #(
    parameter int N     = 8,
    parameter int CNT_W = 8
);
    logic                 rd_valid;
    logic                 rd_ready;
    logic [$clog2(N)-1:0] rd_idx;
    logic [CNT_W-1:0]     rd_count;
    logic                 rd_last;

    modport master (output rd_valid, rd_idx, rd_count, rd_last, input rd_ready);
    modport slave  (input rd_valid, rd_idx, rd_count, rd_last, output rd_ready);
endinterface

// File: rtl/lif_spike_rate_decoder.sv
// lif_spike_rate_decoder: windowed per-neuron spike counter with a banked (index, count) readout stream.
// Optional SKIP_ZERO_EN: readout emits only neurons whose window count is nonzero.
module lif_spike_rate_decoder #(
    parameter int N     = 8,
    parameter int CNT_W = 8,
    parameter int WIN_W = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic [N-1:0]              spikes_in,
    input  logic [WIN_W-1:0]          win_len,
    lif_spike_rate_decoder_if.master  rd,
    output logic                      overrun
);
    localparam int IW = $clog2(N);

    typedef enum logic {IDLE, READOUT} state_t;

    state_t           r_state;
    logic [N-1:0]     r_s_q;
    logic [WIN_W-1:0] r_win_cnt;
    logic [WIN_W-1:0] r_win_len_q;
    logic [CNT_W-1:0] r_cnt [N];
    logic [CNT_W-1:0] r_bank [N];
    logic [IW-1:0]    r_idx;
    logic [CNT_W-1:0] r_count;
    logic             r_last;
    logic             r_overrun;

    logic [CNT_W-1:0] w_cnt_next [N];
    logic [N-1:0]     w_nz_new;
    logic [N-1:0]     w_nz_bank;
    logic [IW:0]      w_new_first;
    logic [IW:0]      w_adv;
    logic             w_new_last;
    logic             w_adv_last;
    logic             w_win_end;
    logic             w_xfer;
    logic             w_idle_next;

    // Lowest set bit of nz at or above start; MSB flags whether one exists.
    function automatic logic [IW:0] scan(input logic [N-1:0] nz, input int start);
        logic [IW:0] res;
        res = '0;
        for (int k = N - 1; k >= 0; k--)
            if (k >= start && nz[k]) res = {1'b1, IW'(k)};
        return res;
    endfunction

    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_cnt_next[k] = &r_cnt[k] ? r_cnt[k] : r_cnt[k] + CNT_W'(r_s_q[k]);
`ifdef SKIP_ZERO_EN
            w_nz_new[k]  = |w_cnt_next[k];
            w_nz_bank[k] = |r_bank[k];
`else
            w_nz_new[k]  = 1'b1;
            w_nz_bank[k] = 1'b1;
`endif
        end
    end

    assign w_new_first = scan(w_nz_new, 0);
    assign w_new_last  = ~|(w_nz_new >> (int'(w_new_first[IW-1:0]) + 1));
    assign w_adv       = scan(w_nz_bank, int'(r_idx) + 1);
    assign w_adv_last  = ~|(w_nz_bank >> (int'(w_adv[IW-1:0]) + 1));
    assign w_win_end   = ena && (r_win_cnt == r_win_len_q);
    assign w_xfer      = (r_state == READOUT) && rd.rd_ready;
    assign w_idle_next = (r_state == IDLE) || (w_xfer && r_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_s_q       <= '0;
            r_win_cnt   <= '0;
            r_win_len_q <= '1;
            r_cnt       <= '{default: '0};
            r_bank      <= '{default: '0};
            r_idx       <= '0;
            r_count     <= '0;
            r_last      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_s_q <= spikes_in;
            if (ena) begin
                r_win_cnt <= w_win_end ? '0 : r_win_cnt + 1'b1;
                for (int k = 0; k < N; k++)
                    r_cnt[k] <= w_win_end ? '0 : w_cnt_next[k];
                if (w_win_end)
                    r_win_len_q <= win_len;
            end
            if (w_xfer) begin
                r_state <= (r_last || !w_adv[IW]) ? IDLE : READOUT;
                r_idx   <= r_last ? '0 : w_adv[IW-1:0];
                r_count <= r_last ? '0 : r_bank[w_adv[IW-1:0]];
                r_last  <= !r_last && w_adv_last;
            end
            // A new snapshot wins over the tail of the previous readout when both land on one edge.
            if (w_win_end && w_new_first[IW]) begin
                if (w_idle_next) begin
                    r_state <= READOUT;
                    r_bank  <= w_cnt_next;
                    r_idx   <= w_new_first[IW-1:0];
                    r_count <= w_cnt_next[w_new_first[IW-1:0]];
                    r_last  <= w_new_last;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign rd.rd_valid = (r_state == READOUT);
    assign rd.rd_idx   = r_idx;
    assign rd.rd_count = r_count;
    assign rd.rd_last  = r_last;
    assign overrun     = r_overrun;
endmodule

// File: tb/tb_lif_spike_rate_decoder.sv
// tb_lif_spike_rate_decoder: directed windows with a queued scoreboard checked by an independent monitor.
module tb_lif_spike_rate_decoder;
    localparam int N = 8, CNT_W = 8, WIN_W = 10;
`ifdef SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] cnt;
        logic       last;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena = 1'b0;
    logic [N-1:0]     spikes_in = '0;
    logic [WIN_W-1:0] win_len = '0;
    logic             overrun;
    logic [7:0]       w [8];
    ev_t              q [$];
    ev_t              mon_e;
    int               errors = 0;
    int               checks = 0;

    lif_spike_rate_decoder_if #(.N(N), .CNT_W(CNT_W)) rd ();

    lif_spike_rate_decoder #(.N(N), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .spikes_in (spikes_in),
        .win_len   (win_len),
        .rd        (rd),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic [7:0] s, input logic r);
        ena = e;
        spikes_in = s;
        rd.rd_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) cyc(1'b0, 8'h00, 1'b1);
        rst_n = 1'b1;
    endtask

    // Expected readout of one window bank, limited to indices below upto.
    task automatic push_window(input logic [7:0] c [8], input int upto);
        ev_t e;
        for (int k = 0; k < upto; k++) begin
            if (!(SKIP && c[k] == 0)) begin
                e.idx  = 3'(k);
                e.cnt  = c[k];
                e.last = (k == N - 1);
                if (SKIP) begin
                    e.last = 1'b1;
                    for (int j = k + 1; j < N; j++)
                        if (c[j] != 0) e.last = 1'b0;
                end
                q.push_back(e);
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || rd.rd_valid) && t < 300) begin
            cyc(1'b0, 8'h00, 1'b1);
            t++;
        end
        chk("drain_queue_empty", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && rd.rd_valid && rd.rd_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got idx %0d count %0d expected no event", rd.rd_idx, rd.rd_count);
            end else begin
                mon_e = q.pop_front();
                chk("ev_idx", rd.rd_idx, mon_e.idx);
                chk("ev_count", rd.rd_count, mon_e.cnt);
                chk("ev_last", rd.rd_last, mon_e.last);
            end
        end
    end

    initial begin
        rd.rd_ready = 1'b1;
        do_reset();
        chk("rst_valid", rd.rd_valid, 0);
        chk("rst_idx", rd.rd_idx, 0);
        chk("rst_count", rd.rd_count, 0);
        chk("rst_last", rd.rd_last, 0);
        chk("rst_overrun", overrun, 0);

        // Neuron 3 pulsed 4 times in the 1024-cycle first window.
        w = '{8'd0, 8'd0, 8'd0, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
        push_window(w, 8);
        win_len = 10'd9;
        for (int i = 1; i <= 1023; i++)
            cyc(1'b1, (i % 100 == 0 && i <= 400) ? 8'h08 : 8'h00, 1'b1);
        chk("t1_no_valid_before_end", rd.rd_valid, 0);
        cyc(1'b1, 8'h00, 1'b1);
        chk("t1_valid_after_end", rd.rd_valid, 1);
        chk("t1_first_idx", rd.rd_idx, SKIP ? 3 : 0);
        drain();
        chk("t1_overrun", overrun, 0);

        // Saturation: 10-cycle zero window loads win_len=299, then spikes[0] held high.
        w = '{default: 8'd0};
        push_window(w, 8);
        win_len = 10'd299;
        repeat (10) cyc(1'b1, 8'h00, 1'b1);
        w = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        push_window(w, 8);
        repeat (300) cyc(1'b1, 8'h01, 1'b1);
        drain();

        // Backpressure: win_len=15, rd_ready low for 40 cycles across a second window end.
        w = '{default: 8'd0};
        push_window(w, 8);
        win_len = 10'd15;
        repeat (300) cyc(1'b1, 8'h00, 1'b1);
        drain();
        w = '{8'd3, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0};
        push_window(w, 8);
        for (int i = 1; i <= 16; i++)
            cyc(1'b1, {1'b0, i == 8, 4'b0, (i >= 2 && i <= 6), (i >= 2 && i <= 4)}, 1'b1);
        for (int i = 17; i <= 56; i++) begin
            cyc(i <= 32, (i <= 31) ? 8'hFF : 8'h00, 1'b0);
            if (i == 31) chk("t3_overrun_before_second_end", overrun, 0);
        end
        chk("t3_overrun_set", overrun, 1);
        chk("t3_hold_valid", rd.rd_valid, 1);
        chk("t3_hold_idx", rd.rd_idx, 0);
        chk("t3_hold_count", rd.rd_count, 3);
        drain();

        // Window end lands on the idx-7 transfer.
        do_reset();
        w = '{8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        push_window(w, 8);
        win_len = 10'd9;
        for (int i = 1; i <= 1024; i++)
            cyc(1'b1, (i == 500 || i == 600) ? 8'h04 : 8'h00, 1'b1);
        w = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0};
        push_window(w, 8);
        for (int i = 1025; i <= 1034; i++)
            cyc(1'b1, (i == 1028) ? 8'h20 : 8'h00, i >= 1027);
        chk("t4_overrun", overrun, 0);
        chk("t4_valid", rd.rd_valid, 1);
        chk("t4_idx", rd.rd_idx, SKIP ? 5 : 0);
        chk("t4_count", rd.rd_count, SKIP ? 1 : 0);
        drain();

        // Reset mid-readout at idx 4.
        do_reset();
        w = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        push_window(w, 4);
        for (int i = 1; i <= 1024; i++)
            cyc(1'b1, (i == 300) ? 8'h02 : 8'h00, 1'b1);
        repeat (4) cyc(1'b0, 8'h00, 1'b1);
        chk("t5_pre_idx", rd.rd_idx, SKIP ? 0 : 4);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", rd.rd_valid, 0);
        chk("t5_rst_idx", rd.rd_idx, 0);
        chk("t5_rst_count", rd.rd_count, 0);
        chk("t5_rst_last", rd.rd_last, 0);
        chk("t5_rst_overrun", overrun, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t5_queue_after_abort", q.size(), 0);
        w = '{default: 8'd0};
        push_window(w, 8);
        repeat (1023) cyc(1'b1, 8'h00, 1'b1);
        chk("t5_no_valid_at_1023", rd.rd_valid, 0);
        cyc(1'b1, 8'h00, 1'b1);
        chk("t5_valid_at_1024", rd.rd_valid, SKIP ? 0 : 1);
        chk("t5_first_idx", rd.rd_idx, 0);
        drain();

        // Only neurons 2 and 5 spike, then an all-zero window.
        w = '{8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0};
        push_window(w, 8);
        for (int i = 1; i <= 10; i++)
            cyc(1'b1, {2'b0, (i == 4 || i == 5), 2'b0, i == 3, 2'b0}, 1'b1);
        w = '{default: 8'd0};
        push_window(w, 8);
        repeat (10) cyc(1'b1, 8'h00, 1'b1);
        drain();
        chk("t6_overrun", overrun, 0);

        chk("final_queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
